hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_AW, default 5, register-address width.
REQ-002 Parameter LOAD_LAT, default 2, total load-use stall cycles, legal range 1..7.
REQ-003 Parameter MD_LAT, default 8, mult/div busy cycles after issue, legal range 1..63.
REQ-004 clk  in  1  single clock; all state on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 rs_d, rt_d  in  REG_AW each  source registers of the instruction in ID.
REQ-007 rs_used_d, rt_used_d  in  1 each  the ID instruction actually reads rs / rt.
REQ-008 branch_d  in  1  branch in ID that compares operands in ID.
REQ-009 wr_x  in  REG_AW  destination register of the instruction in EX.
REQ-010 regwrite_x, memread_x  in  1 each  the EX instruction writes a register / is a load.
REQ-011 md_start_d, md_read_d  in  1 each  ID issues mult/div / reads HI-LO.
REQ-012 pcsrc  in  1  jump redirect taken in ID.
REQ-013 br_taken  in  1  branch resolved taken.
REQ-014 pc_en, if_id_en  out  1 each  PC / IF-ID register update enables.
REQ-015 flush_if_id, flush_id_exe  out  1 each  bubble insertion into IF-ID / ID-EX.
REQ-016 md_busy  out  1  mult/div unit occupied.

Function
REQ-017 Load-use hit = memread_x & wr_x!=0 & ((rs_used_d & rs_d==wr_x) | (rt_used_d & rt_d==wr_x)).
REQ-018 Branch hit = branch_d & regwrite_x & wr_x!=0 & rs/rt match as in REQ-017; stalls exactly 1 cycle, combinational only.
REQ-019 FSM states IDLE, LD_STALL; IDLE->LD_STALL on load-use hit when LOAD_LAT>1, loading ld_cnt with LOAD_LAT-2.
REQ-020 LD_STALL decrements ld_cnt each cycle and returns to IDLE in the cycle after ld_cnt==0, so total stall = LOAD_LAT cycles including the detection cycle.
REQ-021 Stall cycle: pc_en=0, if_id_en=0, flush_id_exe=1, flush_if_id=0.
REQ-022 md_start_d with md_busy=0 loads md_cnt with MD_LAT, sets md_busy next cycle; md_cnt decrements each cycle, md_busy clears when md_cnt reaches 0.
REQ-023 md_start_d or md_read_d while md_busy=1 is a stall cycle (REQ-021); md_cnt keeps counting during any stall.
REQ-024 pcsrc=1 with no stall: flush_if_id=1; with a stall active, the stall wins and the flush is suppressed.
REQ-025 br_taken=1: flush_if_id=1, flush_id_exe=1, pc_en=1, if_id_en=1; FSM forced to IDLE, ld_cnt cleared; md_cnt unaffected.
REQ-026 Priority, highest first: br_taken, stall (load, md, branch), pcsrc.
REQ-027 No stall or flush condition: pc_en=1, if_id_en=1, both flushes 0.

Reset
REQ-028 rst_n low: state IDLE, ld_cnt=0, md_cnt=0, md_busy=0, pc_en=1, if_id_en=1, flush_if_id=0, flush_id_exe=0, asynchronously.
REQ-029 Reset asserted mid-stall aborts it; the first cycle after release behaves as IDLE.

Configuration
REQ-030 With HAZARD_PERF_CNT_EN defined: output stall_cycles, 16 bits, counts every stall cycle, saturates at 16'hFFFF, resets to 0.
REQ-031 Without HAZARD_PERF_CNT_EN: port and counter are absent; all other behaviour is identical.

Verification
REQ-032 LOAD_LAT=2; load wr_x=5 in EX, ID rs_d=5, rs_used_d=1 -> pc_en=0, flush_id_exe=1 for exactly 2 cycles, then pc_en=1.
REQ-033 Load with wr_x=0 matching rs_d=0 -> no stall; with rt_used_d=0 and rt_d match -> no stall.
REQ-034 MD_LAT=4; md_start_d at cycle 0, md_read_d held -> stall cycles 1-4, md_busy low at cycle 5, pc_en=1 at cycle 5.
REQ-035 br_taken in the first LD_STALL cycle -> both flushes 1, pc_en=1 that cycle, FSM IDLE next cycle.
REQ-036 pcsrc=1 during a branch-hit stall -> flush_if_id=0, pc_en=0; pcsrc alone next cycle -> flush_if_id=1.
REQ-037 rst_n pulsed low during LD_STALL and md_busy -> all outputs at reset values immediately, md_busy=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use, branch-operand and mult/div stalls, plus jump/branch flushes.
// Latency: outputs are combinational from the ID/EX inputs and the stall FSM/mult-div counters.
// Backpressure: a stall holds PC and IF-ID and injects an ID-EX bubble; a taken branch overrides every stall.
// Optional: define HAZARD_PERF_CNT_EN to add the 16-bit saturating stall_cycles counter output.
module hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 2,
  parameter int MD_LAT   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic              rs_used_d,
  input  logic              rt_used_d,
  input  logic              branch_d,
  input  logic [REG_AW-1:0] wr_x,
  input  logic              regwrite_x,
  input  logic              memread_x,
  input  logic              md_start_d,
  input  logic              md_read_d,
  input  logic              pcsrc,
  input  logic              br_taken,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              flush_if_id,
  output logic              flush_id_exe,
  output logic              md_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);

  typedef enum logic {IDLE, LD_STALL} state_t;

  // The detection cycle is the first stall cycle, so the FSM covers the remaining LOAD_LAT-1.
  localparam bit       LD_MULTI = (LOAD_LAT > 1);
  localparam logic [2:0] LD_INIT = LD_MULTI ? 3'(LOAD_LAT - 2) : 3'd0;
  localparam logic [5:0] MD_INIT = 6'(MD_LAT);

  state_t     state, state_nxt;
  logic [2:0] ld_cnt, ld_cnt_nxt;
  logic [5:0] md_cnt;

  logic rs_hit, rt_hit, src_hit;
  logic ld_hit, br_hit, md_stall, stall;

  assign rs_hit   = rs_used_d & (rs_d == wr_x);
  assign rt_hit   = rt_used_d & (rt_d == wr_x);
  assign src_hit  = (wr_x != '0) & (rs_hit | rt_hit);
  // Only a fresh detection in IDLE counts; LD_STALL already owns the stall.
  assign ld_hit   = memread_x & src_hit & (state == IDLE);
  assign br_hit   = branch_d & regwrite_x & src_hit;
  assign md_stall = md_busy & (md_start_d | md_read_d);
  assign stall    = ld_hit | (state == LD_STALL) | md_stall | br_hit;

  // Load-stall FSM state and remaining-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ld_cnt <= '0;
    end else begin
      state  <= state_nxt;
      ld_cnt <= ld_cnt_nxt;
    end
  end

  // Next-state logic; a taken branch squashes the stalled instruction, so the stall is dropped.
  always_comb begin
    state_nxt  = state;
    ld_cnt_nxt = ld_cnt;
    if (br_taken) begin
      state_nxt  = IDLE;
      ld_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (ld_hit && LD_MULTI) begin
            state_nxt  = LD_STALL;
            ld_cnt_nxt = LD_INIT;
          end
        end
        LD_STALL: begin
          if (ld_cnt == '0) begin
            state_nxt = IDLE;
          end else begin
            ld_cnt_nxt = ld_cnt - 3'd1;
          end
        end
        default: begin
          state_nxt  = IDLE;
          ld_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Mult/div occupancy: counts down from MD_LAT regardless of stalls or flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt  <= '0;
      md_busy <= 1'b0;
    end else if (md_start_d && !md_busy) begin
      md_cnt  <= MD_INIT;
      md_busy <= 1'b1;
    end else if (md_busy) begin
      md_cnt  <= md_cnt - 6'd1;
      md_busy <= (md_cnt != 6'd1);
    end
  end

  // Output priority: taken branch, then any stall, then jump redirect. Reset forces idle values.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    flush_if_id  = 1'b0;
    flush_id_exe = 1'b0;
    if (!rst_n) begin
      pc_en = 1'b1;
    end else if (br_taken) begin
      flush_if_id  = 1'b1;
      flush_id_exe = 1'b1;
    end else if (stall) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      flush_id_exe = 1'b1;
    end else if (pcsrc) begin
      flush_if_id = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating count of cycles in which the front end was actually held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (!pc_en && stall_cycles != 16'hFFFF) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl with LOAD_LAT=2, MD_LAT=4.
// Expected output vectors are queued when each cycle's stimulus is applied and compared mid-cycle.
// Output vector order: {pc_en, if_id_en, flush_if_id, flush_id_exe, md_busy}.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs_d, rt_d, wr_x;
  logic       rs_used_d, rt_used_d, branch_d, regwrite_x, memread_x;
  logic       md_start_d, md_read_d, pcsrc, br_taken;
  logic       pc_en, if_id_en, flush_if_id, flush_id_exe, md_busy;

  int n_run  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rsu;
    logic       rtu;
    logic       br;
    logic [4:0] wr;
    logic       rw;
    logic       mr;
    logic       ms;
    logic       mrd;
    logic       pc;
    logic       bt;
  } stim_t;

  localparam logic [4:0] RUN   = 5'b11000;
  localparam logic [4:0] RUNB  = 5'b11001;
  localparam logic [4:0] STALL = 5'b00010;
  localparam logic [4:0] STLB  = 5'b00011;
  localparam logic [4:0] PCS   = 5'b11100;
  localparam logic [4:0] BRT   = 5'b11110;
  localparam logic [4:0] BRTB  = 5'b11111;

  logic [4:0] exp_q[$];

  hazard_ctrl #(.REG_AW(5), .LOAD_LAT(2), .MD_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_d(rs_d), .rt_d(rt_d), .rs_used_d(rs_used_d), .rt_used_d(rt_used_d),
    .branch_d(branch_d), .wr_x(wr_x), .regwrite_x(regwrite_x), .memread_x(memread_x),
    .md_start_d(md_start_d), .md_read_d(md_read_d), .pcsrc(pcsrc), .br_taken(br_taken),
    .pc_en(pc_en), .if_id_en(if_id_en), .flush_if_id(flush_if_id),
    .flush_id_exe(flush_id_exe), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  function automatic stim_t st(input logic [4:0] rs, input logic [4:0] rt, input logic rsu,
                               input logic rtu, input logic br, input logic [4:0] wr,
                               input logic rw, input logic mr, input logic ms,
                               input logic mrd, input logic pc, input logic bt);
    stim_t s;
    s = '{rs, rt, rsu, rtu, br, wr, rw, mr, ms, mrd, pc, bt};
    return s;
  endfunction

  function automatic logic [4:0] obs();
    return {pc_en, if_id_en, flush_if_id, flush_id_exe, md_busy};
  endfunction

  task automatic drive(input stim_t s);
    rs_d = s.rs; rt_d = s.rt; rs_used_d = s.rsu; rt_used_d = s.rtu; branch_d = s.br;
    wr_x = s.wr; regwrite_x = s.rw; memread_x = s.mr; md_start_d = s.ms;
    md_read_d = s.mrd; pcsrc = s.pc; br_taken = s.bt;
  endtask

  // Apply one cycle of stimulus just after the rising edge and queue its expected outputs.
  task automatic apply(input stim_t s, input logic [4:0] e);
    @(posedge clk);
    #1;
    drive(s);
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    logic [4:0] got, exp;
    drive('0);
    rst_n = 1'b0;
    #2;
    exp_q.push_back(RUN);
    got = obs(); exp = exp_q.pop_front(); n_run++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_initial got=%b exp=%b", got, exp); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      apply('0, RUN);
      @(negedge clk);
      got = obs(); exp = exp_q.pop_front(); n_run++;
      if (got !== exp) begin n_fail++; $display("FAIL reset_idle[%0d] got=%b exp=%b", i, got, exp); end
    end
  endtask

  task automatic test_load_use();
    stim_t s[4]; logic [4:0] e[4]; logic [4:0] got, exp;
    s = '{st(5,0,1,0,0, 5,1,1, 0,0,0,0), st(5,0,1,0,0, 0,0,0, 0,0,0,0),
          st(5,0,1,0,0, 0,0,0, 0,0,0,0), '0};
    e = '{STALL, STALL, RUN, RUN};
    for (int i = 0; i < 4; i++) begin
      apply(s[i], e[i]);
      @(negedge clk);
      got = obs(); exp = exp_q.pop_front(); n_run++;
      if (got !== exp) begin n_fail++; $display("FAIL load_use[%0d] got=%b exp=%b", i, got, exp); end
    end
  endtask

  task automatic test_no_stall();
    stim_t s[5]; logic [4:0] e[5]; logic [4:0] got, exp;
    s = '{st(0,0,1,0,0, 0,1,1, 0,0,0,0), st(3,5,1,0,0, 5,1,1, 0,0,0,0),
          st(3,5,1,1,0, 5,1,1, 0,0,0,0), st(3,5,1,1,0, 0,0,0, 0,0,0,0), '0};
    e = '{RUN, RUN, STALL, STALL, RUN};
    for (int i = 0; i < 5; i++) begin
      apply(s[i], e[i]);
      @(negedge clk);
      got = obs(); exp = exp_q.pop_front(); n_run++;
      if (got !== exp) begin n_fail++; $display("FAIL no_stall[%0d] got=%b exp=%b", i, got, exp); end
    end
  endtask

  task automatic test_md();
    stim_t s[19]; logic [4:0] e[19]; logic [4:0] got, exp;
    stim_t ms, rd, mb;
    ms = st(0,0,0,0,0, 0,0,0, 1,0,0,0);
    rd = st(0,0,0,0,0, 0,0,0, 0,1,0,0);
    mb = st(0,0,0,0,0, 0,0,0, 0,1,0,1);
    s = '{ms, rd, rd, rd, rd, rd,
          ms, ms, '0, '0, '0, '0,
          ms, mb, '0, '0, '0, '0, '0};
    e = '{RUN, STLB, STLB, STLB, STLB, RUN,
          RUN, STLB, RUNB, RUNB, RUNB, RUN,
          RUN, BRTB, RUNB, RUNB, RUNB, RUN, RUN};
    for (int i = 0; i < 19; i++) begin
      apply(s[i], e[i]);
      @(negedge clk);
      got = obs(); exp = exp_q.pop_front(); n_run++;
      if (got !== exp) begin n_fail++; $display("FAIL md[%0d] got=%b exp=%b", i, got, exp); end
    end
  endtask

  task automatic test_branch_flush();
    stim_t s[5]; logic [4:0] e[5]; logic [4:0] got, exp;
    s = '{st(5,0,1,0,0, 5,1,1, 0,0,0,0), st(5,0,1,0,0, 0,0,0, 0,0,0,1), '0,
          st(5,0,1,0,0, 5,1,1, 0,0,0,1), '0};
    e = '{STALL, BRT, RUN, BRT, RUN};
    for (int i = 0; i < 5; i++) begin
      apply(s[i], e[i]);
      @(negedge clk);
      got = obs(); exp = exp_q.pop_front(); n_run++;
      if (got !== exp) begin n_fail++; $display("FAIL branch_flush[%0d] got=%b exp=%b", i, got, exp); end
    end
  endtask

  task automatic test_pcsrc();
    stim_t s[5]; logic [4:0] e[5]; logic [4:0] got, exp;
    s = '{st(0,7,0,1,1, 7,1,0, 0,0,1,0), st(0,0,0,0,0, 0,0,0, 0,0,1,0),
          st(0,0,1,1,1, 0,1,0, 0,0,0,0), st(0,7,0,1,1, 7,0,0, 0,0,0,0), '0};
    e = '{STALL, PCS, RUN, RUN, RUN};
    for (int i = 0; i < 5; i++) begin
      apply(s[i], e[i]);
      @(negedge clk);
      got = obs(); exp = exp_q.pop_front(); n_run++;
      if (got !== exp) begin n_fail++; $display("FAIL pcsrc[%0d] got=%b exp=%b", i, got, exp); end
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] got, exp;
    apply(st(5,0,1,0,0, 5,1,1, 1,0,0,0), STALL);
    @(negedge clk);
    got = obs(); exp = exp_q.pop_front(); n_run++;
    if (got !== exp) begin n_fail++; $display("FAIL rst_mid_detect got=%b exp=%b", got, exp); end
    apply(st(5,0,1,0,0, 0,0,0, 0,1,0,0), STLB);
    @(negedge clk);
    got = obs(); exp = exp_q.pop_front(); n_run++;
    if (got !== exp) begin n_fail++; $display("FAIL rst_mid_ldstall got=%b exp=%b", got, exp); end
    #1;
    rst_n = 1'b0;
    exp_q.push_back(RUN);
    #1;
    got = obs(); exp = exp_q.pop_front(); n_run++;
    if (got !== exp) begin n_fail++; $display("FAIL rst_mid_async got=%b exp=%b", got, exp); end
    #1;
    rst_n = 1'b1;
    apply(st(5,0,1,0,0, 0,0,0, 0,1,0,0), RUN);
    @(negedge clk);
    got = obs(); exp = exp_q.pop_front(); n_run++;
    if (got !== exp) begin n_fail++; $display("FAIL rst_mid_after got=%b exp=%b", got, exp); end
    apply('0, RUN);
    @(negedge clk);
    got = obs(); exp = exp_q.pop_front(); n_run++;
    if (got !== exp) begin n_fail++; $display("FAIL rst_mid_idle got=%b exp=%b", got, exp); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_md();
    test_branch_flush();
    test_pcsrc();
    test_reset_mid();
    n_run++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
